// File: rtl/mm_uart.sv
// mm_uart: memory-mapped 8N1 UART with TX/RX FIFOs, programmable bit divisor and sticky FERR/OVR flags.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module mm_uart #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RST    = 16'd434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        we,
   input  logic        re,
   output logic [15:0] rdata,
   output logic        TX,
   input  logic        RX
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   logic          sel_data, sel_stat, sel_div;
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
   logic [CW-1:0] tx_cnt_q, rx_cnt_q;
   logic [15:0]   div_q, per_d;
   logic          ferr_q, ovr_q;
   logic          tx_push, tx_pop, rx_push, rx_pop, rx_done, tx_end, rx_end, rx_half, fall;
   state_t        tx_st_q, rx_st_q;
   logic [15:0]   tx_per_q, tx_ctr_q, rx_per_q, rx_ctr_q;
   logic [2:0]    tx_bit_q, rx_bit_q;
   logic [7:0]    tx_sh_q, rx_sh_q;
   logic          tx_q, s1_q, s2_q, prev_q;
   logic [1:0]    vld_q;
   assign sel_data = addr == 16'hC004;
   assign sel_stat = addr == 16'hC005;
   assign sel_div  = addr == 16'hC006;
   assign per_d    = div_q < 16'd16 ? 16'd16 : div_q;
   assign tx_push  = we & sel_data & (tx_cnt_q != FULL);
   assign rx_pop   = re & sel_data & (rx_cnt_q != '0);
   assign tx_end   = tx_ctr_q == tx_per_q - 16'd1;
   assign tx_pop   = (tx_cnt_q != '0) & ((tx_st_q == S_IDLE) | ((tx_st_q == S_STOP) & tx_end));
   assign rx_end   = rx_ctr_q == rx_per_q - 16'd1;
   assign rx_half  = rx_ctr_q == (rx_per_q >> 1) - 16'd1;
   assign rx_done  = (rx_st_q == S_STOP) & rx_end;
   assign rx_push  = rx_done & s2_q & (rx_cnt_q != FULL);
   assign fall     = prev_q & ~s2_q;
   assign TX       = tx_q;
   always_comb begin
      rdata = 16'h0000;
      if (re | we)
         rdata = sel_data ? {8'h00, rx_cnt_q != '0 ? rx_mem[rx_rp_q] : 8'h00} :
                 sel_stat ? {6'h00, ferr_q, ovr_q, 4'(FULL - tx_cnt_q), 4'(rx_cnt_q)} :
                 sel_div  ? div_q : 16'h0000;
   end
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp_q] <= wdata[7:0];
      if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
   end
   // Flag set wins over a same-cycle STATUS write clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q    <= DIV_RST;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (we & sel_div) div_q <= wdata;
         ferr_q <= (rx_done & ~s2_q) | (ferr_q & ~(we & sel_stat));
         ovr_q  <= (rx_done & s2_q & (rx_cnt_q == FULL)) | (ovr_q & ~(we & sel_stat));
         if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
         if (tx_pop) tx_rp_q <= tx_rp_q + AW'(1);
         tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
         if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
         if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
         rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      end
   end
   // The line register follows the state one cycle later, giving the two-edge write-to-start latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_st_q  <= S_IDLE;
         tx_per_q <= 16'd16;
         tx_ctr_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         tx_q <= tx_st_q == S_START ? 1'b0 : tx_st_q == S_DATA ? tx_sh_q[0] : 1'b1;
         if (tx_pop) begin
            tx_st_q  <= S_START;
            tx_sh_q  <= tx_mem[tx_rp_q];
            tx_per_q <= per_d;
            tx_ctr_q <= '0;
         end else if (tx_st_q != S_IDLE) begin
            tx_ctr_q <= tx_end ? 16'd0 : tx_ctr_q + 16'd1;
            if (tx_end) begin
               case (tx_st_q)
                  S_START: begin
                     tx_st_q  <= S_DATA;
                     tx_bit_q <= '0;
                  end
                  S_DATA: begin
                     tx_sh_q  <= tx_sh_q >> 1;
                     tx_bit_q <= tx_bit_q + 3'd1;
                     if (tx_bit_q == 3'd7) tx_st_q <= S_STOP;
                  end
                  default: tx_st_q <= S_IDLE;
               endcase
            end
         end
      end
   end
   // prev_q stays low until the synchronizer carries a real high, so a line held low at release is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= 1'b1;
         s2_q     <= 1'b1;
         vld_q    <= '0;
         prev_q   <= 1'b0;
         rx_st_q  <= S_IDLE;
         rx_per_q <= 16'd16;
         rx_ctr_q <= '0;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
      end else begin
         s1_q   <= RX;
         s2_q   <= s1_q;
         vld_q  <= {vld_q[0], 1'b1};
         prev_q <= vld_q[1] & s2_q;
         case (rx_st_q)
            S_IDLE: if (fall) begin
               rx_st_q  <= S_START;
               rx_per_q <= per_d;
               rx_ctr_q <= '0;
            end
            S_START: if (rx_half) begin
               rx_st_q  <= s2_q ? S_IDLE : S_DATA;
               rx_ctr_q <= '0;
               rx_bit_q <= '0;
            end else rx_ctr_q <= rx_ctr_q + 16'd1;
            S_DATA: if (rx_end) begin
               rx_sh_q  <= {s2_q, rx_sh_q[7:1]};
               rx_bit_q <= rx_bit_q + 3'd1;
               rx_ctr_q <= '0;
               if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
            end else rx_ctr_q <= rx_ctr_q + 16'd1;
            default: if (rx_end) rx_st_q <= S_IDLE;
               else rx_ctr_q <= rx_ctr_q + 16'd1;
         endcase
      end
   end
endmodule
